// File: rtl/pitch_frame_ctrl.sv
// pitch_frame_ctrl: frame sequencer for the pitch-detection path.
// Gates one frame of audio into the FFT and forwards the magnitude stream
// to the peak finder as one unbroken window. It then thresholds the peak
// result and hands one pitch result per frame downstream over valid/ready.
module pitch_frame_ctrl #(
    parameter int NSamples    = 256,
    parameter int W           = 33,
    parameter int DW          = 16,
    parameter int NBits       = $clog2(NSamples),
    parameter int PeakTimeout = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [W-1:0]     threshold,
    input  logic [DW-1:0]    audio_data,
    input  logic             audio_valid,
    output logic             audio_ready,
    output logic [DW-1:0]    fft_in_data,
    output logic             fft_in_valid,
    output logic             fft_in_last,
    input  logic             fft_in_ready,
    input  logic [W-1:0]     fft_mag,
    input  logic             fft_mag_valid,
    output logic [W-1:0]     mag_out,
    output logic             mag_out_valid,
    input  logic [W-1:0]     peak_in,
    input  logic [NBits-1:0] peak_k_in,
    input  logic             peak_in_valid,
    output logic [NBits-1:0] pitch_k,
    output logic             pitch_voiced,
    output logic             pitch_valid,
    input  logic             pitch_ready,
    output logic             busy,
    output logic             err,
    output logic [15:0]      frame_count
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FILL      = 3'd1;
    localparam logic [2:0] S_WAIT_MAG  = 3'd2;
    localparam logic [2:0] S_STREAM    = 3'd3;
    localparam logic [2:0] S_WAIT_PEAK = 3'd4;
    localparam logic [2:0] S_RESULT    = 3'd5;

    // Timeout counter only has to reach PeakTimeout-1.
    localparam int TW = (PeakTimeout > 1) ? $clog2(PeakTimeout) : 1;

    localparam logic [NBits-1:0] SMP_LAST = NBits'(NSamples - 1);
    localparam logic [NBits:0]   BEATS    = (NBits + 1)'(NSamples);
    localparam logic [TW-1:0]    TO_LAST  = TW'(PeakTimeout - 1);

    logic [2:0]       state_q, state_d;
    logic [NBits-1:0] smp_cnt_q, smp_cnt_d;
    logic [NBits:0]   beat_cnt_q, beat_cnt_d;
    logic [TW-1:0]    to_cnt_q, to_cnt_d;
    logic [W-1:0]     mag_out_q, mag_out_d;
    logic             mag_vld_q, mag_vld_d;
    logic [NBits-1:0] pitch_k_q, pitch_k_d;
    logic             voiced_q, voiced_d;
    logic             pitch_vld_q, pitch_vld_d;
    logic             err_q, err_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    logic fill;
    assign fill = (state_q == S_FILL);

    // Audio path is a zero-latency pass-through, open only while filling.
    assign fft_in_data  = fill ? audio_data : '0;
    assign fft_in_valid = fill & audio_valid;
    assign audio_ready  = fill & fft_in_ready;
    assign fft_in_last  = fill & (smp_cnt_q == SMP_LAST);

    assign mag_out       = mag_out_q;
    assign mag_out_valid = mag_vld_q;
    assign pitch_k       = pitch_k_q;
    assign pitch_voiced  = voiced_q;
    assign pitch_valid   = pitch_vld_q;
    assign err           = err_q;
    assign frame_count   = frame_cnt_q;
    assign busy          = (state_q != S_IDLE);

    // Frame sequencing: next state and all registered outputs.
    always_comb begin
        state_d     = state_q;
        smp_cnt_d   = smp_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        to_cnt_d    = to_cnt_q;
        mag_out_d   = mag_out_q;
        mag_vld_d   = mag_vld_q;
        pitch_k_d   = pitch_k_q;
        voiced_d    = voiced_q;
        pitch_vld_d = pitch_vld_q;
        err_d       = err_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    smp_cnt_d = '0;
                    state_d   = S_FILL;
                end
            end
            S_FILL: begin
                if (audio_valid && fft_in_ready) begin
                    smp_cnt_d = smp_cnt_q + 1'b1;
                    if (smp_cnt_q == SMP_LAST) state_d = S_WAIT_MAG;
                end
            end
            S_WAIT_MAG: begin
                // First valid beat opens the window and counts as beat 1.
                if (fft_mag_valid) begin
                    mag_out_d  = fft_mag;
                    mag_vld_d  = 1'b1;
                    beat_cnt_d = (NBits + 1)'(1);
                    state_d    = S_STREAM;
                end
            end
            S_STREAM: begin
                // Full window check comes first so surplus beats are ignored.
                if (beat_cnt_q == BEATS) begin
                    mag_vld_d = 1'b0;
                    to_cnt_d  = '0;
                    state_d   = S_WAIT_PEAK;
                end else if (fft_mag_valid) begin
                    mag_out_d  = fft_mag;
                    mag_vld_d  = 1'b1;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end else begin
                    // A gap would corrupt the peak search: abort the frame.
                    mag_vld_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_WAIT_PEAK: begin
                if (peak_in_valid) begin
                    pitch_k_d   = peak_k_in;
                    voiced_d    = (peak_in >= threshold);
                    pitch_vld_d = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = S_RESULT;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_RESULT: begin
                if (pitch_ready) begin
                    pitch_vld_d = 1'b0;
                    smp_cnt_d   = '0;
                    state_d     = enable ? S_FILL : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            smp_cnt_q   <= '0;
            beat_cnt_q  <= '0;
            to_cnt_q    <= '0;
            mag_out_q   <= '0;
            mag_vld_q   <= 1'b0;
            pitch_k_q   <= '0;
            voiced_q    <= 1'b0;
            pitch_vld_q <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            smp_cnt_q   <= smp_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            to_cnt_q    <= to_cnt_d;
            mag_out_q   <= mag_out_d;
            mag_vld_q   <= mag_vld_d;
            pitch_k_q   <= pitch_k_d;
            voiced_q    <= voiced_d;
            pitch_vld_q <= pitch_vld_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_pitch_frame_ctrl.sv
// Bench for pitch_frame_ctrl: randomized frames against a transaction-level
// model. The bench plays audio source, FFT, peak finder and downstream sink.
module tb_pitch_frame_ctrl;
    localparam int N  = 256;
    localparam int W  = 33;
    localparam int DW = 16;
    localparam int NB = 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset, enable;
    logic [W-1:0] threshold;
    logic [DW-1:0] audio_data;
    logic audio_valid, audio_ready;
    logic [DW-1:0] fft_in_data;
    logic fft_in_valid, fft_in_last, fft_in_ready;
    logic [W-1:0] fft_mag;
    logic fft_mag_valid;
    logic [W-1:0] mag_out;
    logic mag_out_valid;
    logic [W-1:0] peak_in;
    logic [NB-1:0] peak_k_in;
    logic peak_in_valid;
    logic [NB-1:0] pitch_k;
    logic pitch_voiced, pitch_valid, pitch_ready, busy, err;
    logic [15:0] frame_count;

    pitch_frame_ctrl dut (
        .clk(clk), .reset(reset), .enable(enable), .threshold(threshold),
        .audio_data(audio_data), .audio_valid(audio_valid), .audio_ready(audio_ready),
        .fft_in_data(fft_in_data), .fft_in_valid(fft_in_valid), .fft_in_last(fft_in_last),
        .fft_in_ready(fft_in_ready), .fft_mag(fft_mag), .fft_mag_valid(fft_mag_valid),
        .mag_out(mag_out), .mag_out_valid(mag_out_valid), .peak_in(peak_in),
        .peak_k_in(peak_k_in), .peak_in_valid(peak_in_valid), .pitch_k(pitch_k),
        .pitch_voiced(pitch_voiced), .pitch_valid(pitch_valid), .pitch_ready(pitch_ready),
        .busy(busy), .err(err), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Window monitor: records every mag_out_valid run and its data.
    int run_len = 0;
    int runs[$];
    logic [W-1:0] mon_q[$];
    always @(negedge clk) begin
        if (mag_out_valid === 1'b1) begin
            run_len++;
            mon_q.push_back(mag_out);
        end else if (run_len != 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end
    end

    // Model state
    logic [15:0] fc_exp;
    logic err_exp;
    logic [W-1:0] mags[N];
    int pk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NB-1:0] bitrev(input int i);
        logic [NB-1:0] r;
        for (int b = 0; b < NB; b++) r[b] = i[NB-1-b];
        return r;
    endfunction

    // Build a magnitude frame in FFT (bit-reversed) order and pick its peak
    // the way a first-max peak finder would.
    task automatic gen_mags(input int kind);
        logic [31:0] t;
        for (int i = 0; i < N; i++) begin
            t = $urandom;
            case (kind)
                0: mags[i] = W'($urandom_range(99, 0));
                1: mags[i] = W'(50);
                default: mags[i] = {t[0], 32'($urandom)};
            endcase
        end
        if (kind == 0) mags[bitrev(5)] = W'(500);
        pk = 0;
        for (int i = 1; i < N; i++) if (mags[i] > mags[pk]) pk = i;
    endtask

    task automatic start_frame();
        enable = 1'b1;
        if (busy !== 1'b1) tick();
        runs.delete();
        mon_q.delete();
    endtask

    task automatic do_fill(input int pct, input int vpct);
        int cnt = 0;
        int errs = 0;
        int lasts = 0;
        int cyc = 0;
        while (cnt < N && cyc < 20000) begin
            audio_valid  = ($urandom_range(99, 0) < vpct);
            audio_data   = DW'($urandom);
            fft_in_ready = ($urandom_range(99, 0) < pct);
            #1;
            if (fft_in_data !== audio_data || fft_in_valid !== audio_valid ||
                audio_ready !== fft_in_ready) errs++;
            if (fft_in_last !== (cnt == N - 1)) errs++;
            if (fft_in_last && audio_valid && fft_in_ready) lasts++;
            if (audio_valid && fft_in_ready) cnt++;
            tick();
            cyc++;
        end
        check("fill_pass", errs, 0);
        check("fill_cnt", cnt, N);
        check("fill_last", lasts, 1);
        audio_valid  = 1'b1;
        fft_in_ready = 1'b1;
        #1;
        check("ready_after_fill", audio_ready, 0);
        audio_valid = 1'b0;
    endtask

    // Drive nbeats+extra contiguous magnitudes; stop at the window's fall.
    task automatic do_stream(input int nbeats, input int extra, output bit fell);
        int i = 0;
        bit seen = 0;
        fell = 0;
        fft_mag_valid = 1'b0;
        repeat ($urandom_range(3, 0)) tick();
        for (int c = 0; c < N + 20; c++) begin
            if (i < nbeats + extra) begin
                fft_mag_valid = 1'b1;
                fft_mag = (i < N) ? mags[i] : W'($urandom);
                i++;
            end else begin
                fft_mag_valid = 1'b0;
                fft_mag = W'($urandom);
            end
            tick();
            if (mag_out_valid === 1'b1) seen = 1;
            else if (seen) begin
                fell = 1;
                break;
            end
        end
        fft_mag_valid = 1'b0;
    endtask

    task automatic check_window(input int len, input bit data);
        int errs = 0;
        check("win_runs", runs.size(), 1);
        if (runs.size() > 0) check("win_len", runs[0], len);
        if (data) begin
            if (mon_q.size() != N) errs++;
            else for (int i = 0; i < N; i++) if (mon_q[i] !== mags[i]) errs++;
            check("win_data", errs, 0);
        end
    endtask

    task automatic run_good(input int kind, input int pct, input int vpct, input int delay,
                            input int hold, input bit en_next, input int thr_mode);
        bit fell;
        int errs = 0;
        logic [NB-1:0] k0;
        logic v0;
        logic exp_v;
        start_frame();
        gen_mags(kind);
        case (thr_mode)
            0: threshold = W'(100);
            1: threshold = mags[pk];
            2: threshold = mags[pk] + 1'b1;
            default: threshold = {1'($urandom_range(1, 0)), 32'($urandom)};
        endcase
        do_fill(pct, vpct);
        enable = en_next;
        do_stream(N, $urandom_range(1, 0), fell);
        check("stream_end", fell, 1);
        for (int d = 0; d < delay; d++) begin
            peak_in = W'($urandom);
            peak_k_in = NB'($urandom);
            tick();
        end
        peak_in_valid = 1'b1;
        peak_in = mags[pk];
        peak_k_in = bitrev(pk);
        tick();
        peak_in_valid = 1'b0;
        exp_v = (mags[pk] >= threshold);
        fc_exp = fc_exp + 16'd1;
        check("pitch_valid", pitch_valid, 1);
        check("pitch_k", pitch_k, bitrev(pk));
        check("pitch_voiced", pitch_voiced, exp_v);
        check("frame_count", frame_count, fc_exp);
        check("err", err, err_exp);
        k0 = pitch_k;
        v0 = pitch_voiced;
        fft_in_ready = 1'b1;
        pitch_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tick();
            if (pitch_k !== k0 || pitch_voiced !== v0 || pitch_valid !== 1'b1 ||
                audio_ready !== 1'b0 || frame_count !== fc_exp) errs++;
        end
        check("result_hold", errs, 0);
        pitch_ready = 1'b1;
        tick();
        pitch_ready = 1'b0;
        #1;
        check("pitch_drop", pitch_valid, 0);
        check("next_busy", busy, en_next);
        check("next_ready", audio_ready, en_next);
        check_window(N, 1);
    endtask

    task automatic run_broken(input int brk);
        bit fell;
        start_frame();
        gen_mags(2);
        do_fill(100, 100);
        do_stream(brk, 0, fell);
        err_exp = 1'b1;
        check("brk_fell", fell, 1);
        check("brk_err", err, 1);
        check("brk_busy", busy, 0);
        enable = 1'b0;
        peak_in_valid = 1'b1;
        peak_k_in = NB'(3);
        peak_in = '1;
        tick();
        peak_in_valid = 1'b0;
        tick();
        check("brk_no_result", pitch_valid, 0);
        check("brk_fc", frame_count, fc_exp);
        check_window(brk, 0);
    endtask

    task automatic run_timeout();
        bit fell;
        start_frame();
        gen_mags(2);
        do_fill(100, 100);
        enable = 1'b0;
        do_stream(N, 0, fell);
        check("to_fell", fell, 1);
        repeat (TO - 1) tick();
        check("to_wait_err", err, err_exp);
        check("to_wait_busy", busy, 1);
        tick();
        err_exp = 1'b1;
        check("to_err", err, 1);
        check("to_busy", busy, 0);
        check("to_no_result", pitch_valid, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"}, {mag_out, mag_out_valid, pitch_k, pitch_voiced, pitch_valid, err,
                            frame_count, busy}, 0);
        check({tag, "_b"}, {fft_in_data, fft_in_valid, fft_in_last, audio_ready}, 0);
    endtask

    task automatic run_reset();
        start_frame();
        gen_mags(2);
        do_fill(100, 100);
        for (int c = 0; c < 128; c++) begin
            fft_mag_valid = 1'b1;
            fft_mag = mags[c];
            tick();
        end
        check("mid_stream_vld", mag_out_valid, 1);
        reset = 1'b1;
        enable = 1'b0;
        tick();
        fft_mag_valid = 1'b0;
        reset = 1'b0;
        fc_exp = '0;
        err_exp = 1'b0;
        check_zero("mid_reset");
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; threshold = W'(100);
        audio_data = '0; audio_valid = 1'b0; fft_in_ready = 1'b0;
        fft_mag = '0; fft_mag_valid = 1'b0;
        peak_in = '0; peak_k_in = '0; peak_in_valid = 1'b0; pitch_ready = 1'b0;
        fc_exp = '0; err_exp = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        reset = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        run_good(0, 100, 100, 0, 0, 1, 0);   // nominal: bin 5 = 500
        check("nominal_k5", pitch_k, 5);
        run_good(1, 100, 100, 0, 2, 1, 0);   // unvoiced
        run_good(2, 50, 70, 1, 20, 1, 3);    // backpressure
        run_broken(100);
        run_timeout();
        run_reset();
        run_good(2, 100, 100, 0, 1, 1, 1);
        check("post_reset_fc", frame_count, 1);
        for (int f = 0; f < 6; f++)
            run_good(2, $urandom_range(100, 30), $urandom_range(100, 40),
                     $urandom_range(TO - 1, 0), $urandom_range(5, 0),
                     1'($urandom_range(1, 0)), $urandom_range(3, 0));
        run_good(2, 100, 100, TO - 1, 0, 0, 2);  // latest legal peak, peak < threshold

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pitch_frame_ctrl.md
# pitch_frame_ctrl

Frame sequencer for the microphone pitch-detection path. It gates audio samples into the FFT one frame (NSamples points) at a time and forwards the FFT magnitude stream to the peak finder as a single unbroken window. It then collects the peak result, applies a voicing threshold and hands one pitch result per frame downstream over a valid/ready handshake. It sits between the audio sample source, the FFT core, the peak finder and the pitch-to-note logic.

## Interface
- NSamples, 256, FFT points per frame (power of two)
- W, 33, magnitude width
- DW, 16, audio sample width
- NBits, $clog2(NSamples), k-index width
- PeakTimeout, 8, max cycles to wait for peak result after the last magnitude

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- enable  in  1  run frames continuously while high
- threshold  in  W  minimum peak magnitude counted as voiced
- audio_data  in  DW  sample from microphone path
- audio_valid  in  1  sample valid
- audio_ready  out  1  sample accepted when valid & ready
- fft_in_data  out  DW  sample to FFT
- fft_in_valid  out  1  FFT input valid
- fft_in_last  out  1  marks sample NSamples-1 of a frame
- fft_in_ready  in  1  FFT can accept
- fft_mag  in  W  magnitude from FFT (bit-reversed order)
- fft_mag_valid  in  1  magnitude valid
- mag_out  out  W  magnitude to peak finder
- mag_out_valid  out  1  peak-finder window enable
- peak_in  in  W  peak magnitude from peak finder
- peak_k_in  in  NBits  peak bin from peak finder
- peak_in_valid  in  1  one-cycle peak result pulse
- pitch_k  out  NBits  result bin
- pitch_voiced  out  1  peak_in >= threshold
- pitch_valid  out  1  result valid
- pitch_ready  in  1  downstream accepts result
- busy  out  1  state != IDLE
- err  out  1  sticky error: mag stream broke or peak timeout; cleared by reset only
- frame_count  out  16  completed frames, wraps at 65535 -> 0

## Operation
- States: IDLE, FILL, WAIT_MAG, STREAM, WAIT_PEAK, RESULT.
- IDLE: all handshakes low. Goes to FILL when enable=1.
- FILL:
  - Combinational pass-through: fft_in_data=audio_data, fft_in_valid=audio_valid, audio_ready=fft_in_ready.
  - Sample counter advances on each audio_valid & fft_in_ready.
  - fft_in_last=1 while the counter is NSamples-1.
  - On accepting the last sample, go to WAIT_MAG.
  - audio_ready=0 in every other state.
- WAIT_MAG: waits for fft_mag_valid=1. The first valid beat is captured and the state moves to STREAM.
- STREAM:
  - Registered forward: mag_out<=fft_mag; mag_out_valid<=1 for each beat, counting beats.
  - After exactly NSamples forwarded beats, mag_out_valid<=0 and the state moves to WAIT_PEAK. Extra fft_mag_valid beats are ignored.
  - If fft_mag_valid drops before NSamples beats: mag_out_valid<=0 (which resets the peak finder), err<=1, state goes to IDLE, no result.
- WAIT_PEAK:
  - On peak_in_valid, latch pitch_k=peak_k_in and pitch_voiced=(peak_in>=threshold), unsigned compare.
  - Set pitch_valid=1, frame_count+1, go to RESULT.
  - If no pulse within PeakTimeout cycles: err<=1, go to IDLE.
- RESULT:
  - Hold pitch_k, pitch_voiced and pitch_valid stable until pitch_ready=1.
  - On pitch_valid & pitch_ready: pitch_valid<=0, then go to FILL if enable=1, else IDLE.
- enable low mid-frame: the current frame completes normally, then the block goes to IDLE.
- peak_in_valid outside WAIT_PEAK is ignored.

## Timing
- Reset values: state IDLE; all outputs 0 (mag_out, pitch_k, pitch_voiced, pitch_valid, err, frame_count, busy, fft_in_*, audio_ready). Reset mid-frame drops mag_out_valid on the next edge.
- FILL path has zero latency. Magnitude path has 1-cycle latency.
- mag_out_valid is high for exactly NSamples consecutive cycles per good frame, never split.
- peak_in_valid is expected 1 cycle after the last mag_out_valid cycle.
- pitch_valid rises 1 cycle after peak_in_valid.
- After a result handshake with enable=1, audio_ready can be high on the very next cycle.
- busy is combinational from state.

## Test plan
- Nominal frame: enable=1, threshold=100, feed 256 samples, then 256 contiguous magnitudes with bin 5 = 500 (bit-reversed slot) -> mag_out_valid high exactly 256 cycles; pitch_k=5, pitch_voiced=1, frame_count=1.
- Unvoiced frame: all magnitudes 50, threshold=100 -> pitch_voiced=0, pitch_valid still asserted.
- Backpressure: fft_in_ready toggles 50%, pitch_ready held low 20 cycles -> exactly 256 samples transferred, fft_in_last on the 256th only; pitch_k stable for all 20 cycles; no audio_ready during RESULT.
- Broken stream: fft_mag_valid drops after 100 beats -> mag_out_valid low the next cycle, err=1, state IDLE, no pitch_valid.
- Peak timeout: peak_in_valid withheld -> err=1 after 8 cycles in WAIT_PEAK, busy=0.
- Reset mid-STREAM at beat 128, then enable -> all outputs 0 and the next frame completes with frame_count=1.
